// File: rtl/note_key_debouncer.sv
// Seven-key note front end: per-key 2-flop synchroniser and debounce, then
// lowest-key-wins priority select into registered one-hot / index / strobe outputs.

module note_key_lane #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic stable
);
    logic             s1, s2;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

    // The stable level flips only after DEBOUNCE_CYCLES consecutive mismatches.
    // One matching sample clears the count, so short glitches are discarded.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stable <= 1'b0;
            cnt    <= '0;
        end else if (s2 == stable) begin
            cnt <= '0;
        end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            stable <= s2;
            cnt    <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

module note_key_debouncer #(
    parameter int NUM_KEYS        = 7,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] key_raw,
    output logic [NUM_KEYS-1:0] note_onehot,
    output logic [2:0]          note_idx,
    output logic                note_valid,
    output logic                note_changed,
    output logic [NUM_KEYS-1:0] key_stable
);
    logic [NUM_KEYS-1:0] sel;
    logic [2:0]          sel_idx;

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_lane
        note_key_lane #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_lane (
            .clk   (clk),
            .reset (reset),
            .raw   (key_raw[g]),
            .stable(key_stable[g])
        );
    end

    // Scan from the top down so the lowest set key is the last one written.
    always_comb begin
        sel     = '0;
        sel_idx = 3'd0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (key_stable[i]) begin
                sel     = '0;
                sel[i]  = 1'b1;
                sel_idx = 3'(i + 1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            note_onehot  <= '0;
            note_idx     <= 3'd0;
            note_valid   <= 1'b0;
            note_changed <= 1'b0;
        end else begin
            note_onehot  <= sel;
            note_idx     <= sel_idx;
            note_valid   <= (sel != '0);
            note_changed <= (sel != note_onehot);
        end
    end
endmodule
